serial_demux_1x8: RTL and testbench

- Sequential 1-to-8 demultiplexer (deserializer). It is the receive-side counterpart to the team's 8x1 select mux.
- Each accepted serial bit is steered to lane `i[bit_idx]` of an internal assembly register. After 8 bits, the assembled byte is handed off on a valid/ready output port.
- The assembly register and the output register are double-buffered. Collection of the next byte continues while the previous byte waits for the consumer.

---
 rtl/serial_demux_1x8.sv | 95 +++++++++
 tb/tb_serial_demux_1x8.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : serial_demux_1x8
// Description : Serial 1-to-8 deserializer; steers accepted bits into lanes of
//               an assembly register and hands off bytes on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_demux_1x8 #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sync,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] bit_idx
);

  localparam logic [2:0] c_LAST = 3'd7;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_asm;
  logic [7:0] r_out_byte;
  logic [2:0] r_bit_idx;

  logic       w_accept;
  logic       w_xfer;
  logic       w_complete;
  logic [2:0] w_idx_eff;
  logic [2:0] w_lane;
  logic [7:0] w_base;
  logic [7:0] w_byte;

  assign out_valid = (r_state == HOLD);
  assign out_byte  = r_out_byte;
  assign bit_idx   = r_bit_idx;

  // Only the 8th bit can stall, and only when the held byte is not draining.
  assign in_ready   = !rst && !((r_bit_idx == c_LAST) && out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_xfer     = out_valid && out_ready;
  assign w_complete = w_accept && (r_bit_idx == c_LAST) && !sync;

  // A bit accepted alongside sync becomes bit 0 of a freshly cleared frame.
  always_comb begin
    w_idx_eff = sync ? 3'd0 : r_bit_idx;
    w_lane    = (LSB_FIRST != 0) ? w_idx_eff : (c_LAST - w_idx_eff);
    w_base    = sync ? 8'h00 : r_asm;
    w_byte    = w_base;
    w_byte[w_lane] = in_bit;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_complete) w_state_nxt = HOLD;
      HOLD: begin
        if (w_complete)  w_state_nxt = HOLD;
        else if (w_xfer) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_asm      <= 8'h00;
      r_out_byte <= 8'h00;
      r_bit_idx  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_asm     <= w_byte;
        r_bit_idx <= w_idx_eff + 3'd1;
      end else if (sync) begin
        r_asm     <= 8'h00;
        r_bit_idx <= 3'd0;
      end
      if (w_complete) r_out_byte <= w_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_demux_1x8
// Description : Self-checking bench for serial_demux_1x8 (both bit orders)
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_demux_1x8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_l, in_ready_m;
  logic [7:0] out_byte_l, out_byte_m;
  logic       out_valid_l, out_valid_m;
  logic [2:0] bit_idx_l, bit_idx_m;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the current frame in arrival order, plus the
  // output register contents for each bit order.
  bit       mq[$];
  bit       mv = 1'b0;
  bit [7:0] mb_l = 8'h00;
  bit [7:0] mb_m = 8'h00;

  always #5 clk = ~clk;

  serial_demux_1x8 #(.LSB_FIRST(1)) u_dut_l (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_l), .sync(sync), .out_byte(out_byte_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .bit_idx(bit_idx_l)
  );

  serial_demux_1x8 #(.LSB_FIRST(0)) u_dut_m (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_m), .sync(sync), .out_byte(out_byte_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .bit_idx(bit_idx_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] form_byte(input bit lsb_first);
    bit [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (lsb_first) b[k] = mq[k];
      else           b[7-k] = mq[k];
    end
    return b;
  endfunction

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic r, input logic b, input logic v,
                      input logic s, input logic o);
    bit exp_rdy, acc, xfer, done;
    rst = r; in_bit = b; in_valid = v; sync = s; out_ready = o;
    #1;
    exp_rdy = !r && !((mq.size() == 7) && mv && !o);
    check("in_ready_l", in_ready_l, exp_rdy);
    check("in_ready_m", in_ready_m, exp_rdy);
    @(posedge clk);
    if (r) begin
      mq.delete();
      mv = 1'b0; mb_l = 8'h00; mb_m = 8'h00;
    end else begin
      acc  = v && exp_rdy;
      xfer = mv && o;
      done = 1'b0;
      if (s) begin
        mq.delete();
        if (acc) mq.push_back(b);
      end else if (acc) begin
        mq.push_back(b);
        if (mq.size() == 8) begin
          mb_l = form_byte(1'b1);
          mb_m = form_byte(1'b0);
          mv   = 1'b1;
          done = 1'b1;
          mq.delete();
        end
      end
      if (xfer && !done) mv = 1'b0;
    end
    #1;
    check("out_valid_l", out_valid_l, mv);
    check("out_valid_m", out_valid_m, mv);
    check("out_byte_l", out_byte_l, mb_l);
    check("out_byte_m", out_byte_m, mb_m);
    check("bit_idx_l", bit_idx_l, mq.size());
    check("bit_idx_m", bit_idx_m, mq.size());
    @(negedge clk);
  endtask

  // Send the first n bits of v, bit 0 first.
  task automatic send_bits(input logic [7:0] v, input int n, input logic o);
    for (int k = 0; k < n; k++) step(1'b0, v[k], 1'b1, 1'b0, o);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_out_byte", out_byte_l, 8'h00);
    check("reset_bit_idx", bit_idx_l, 3'd0);

    // Basic stream 1,0,1,1,0,0,1,0
    send_bits(8'b0100_1101, 8, 1'b1);
    check("stream_lsb", out_byte_l, 8'h4D);
    check("stream_msb", out_byte_m, 8'hB2);
    check("stream_valid", out_valid_l, 1'b1);
    check("stream_idx", bit_idx_l, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stream_drained", out_valid_l, 1'b0);

    // Backpressure: A5 held while 7 bits of FF go in, 8th stalls
    send_bits(8'hA5, 8, 1'b0);
    send_bits(8'hFF, 7, 1'b0);
    check("bp_hold_byte", out_byte_l, 8'hA5);
    check("bp_idx7", bit_idx_l, 3'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_stalled_idx", bit_idx_l, 3'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("bp_replace_byte", out_byte_l, 8'hFF);
    check("bp_replace_valid", out_valid_l, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Resync mid-frame, sync bit becomes bit 0
    send_bits(8'h00, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("resync_idx", bit_idx_l, 3'd1);
    check("resync_no_out", out_valid_l, 1'b0);
    send_bits(8'hFF, 7, 1'b1);
    check("resync_byte", out_byte_l, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Sync together with the 8th bit
    send_bits(8'h3C, 7, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sync8_no_valid", out_valid_l, 1'b0);
    check("sync8_idx", bit_idx_l, 3'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset while a byte is pending and a partial is in flight
    send_bits(8'h96, 8, 1'b0);
    send_bits(8'h1F, 5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_mid_valid", out_valid_l, 1'b0);
    check("rst_mid_byte", out_byte_l, 8'h00);
    check("rst_mid_idx", bit_idx_l, 3'd0);
    send_bits(8'hC3, 8, 1'b1);
    check("post_rst_byte", out_byte_l, 8'hC3);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(63) == 0), 1'($urandom), ($urandom_range(3) != 0),
           ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
